// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, bus widths, wait defaults and byte-lane helpers
// for sram_ctrl and its bench.
package sram_pkg;
  localparam int SRAM_DATA_W      = 32;
  localparam int SRAM_BE_W        = 4;
  localparam int SRAM_RD_WAIT_DEF = 1;
  localparam int SRAM_WR_WAIT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_DONE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } sram_state_e;

  function automatic logic [SRAM_DATA_W-1:0] reverse_bytes(input logic [SRAM_DATA_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [SRAM_BE_W-1:0] reverse_be(input logic [SRAM_BE_W-1:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction
endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: single-outstanding request/acknowledge bus between the CPU memory stage
// (master) and one sram_ctrl bank (slave).
interface sram_ctrl_if #(parameter int ADDR_W = 20);
  import sram_pkg::*;
  logic                   req_i;
  logic                   we_i;
  logic [ADDR_W-1:0]      addr_i;
  logic [SRAM_BE_W-1:0]   be_i;
  logic [SRAM_DATA_W-1:0] wdata_i;
  logic [SRAM_DATA_W-1:0] rdata_o;
  logic                   ack_o;

  modport master (output req_i, we_i, addr_i, be_i, wdata_i, input rdata_o, ack_o);
  modport slave  (input req_i, we_i, addr_i, be_i, wdata_i, output rdata_o, ack_o);
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences one asynchronous 32-bit SRAM bank from a req/ack bus; all pins registered.
// Define SRAM_CTRL_REVERSE_ENDIAN_EN to reverse byte lanes (data and BE_n) at the pins.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = SRAM_RD_WAIT_DEF,
  parameter int WR_WAIT = SRAM_WR_WAIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_ctrl_if.slave             bus,
  inout  wire  [SRAM_DATA_W-1:0] ram_data_io,
  output logic [ADDR_W-1:0]      ram_addr_o,
  output logic [SRAM_BE_W-1:0]   ram_be_n_o,
  output logic                   ram_ce_n_o,
  output logic                   ram_oe_n_o,
  output logic                   ram_we_n_o
);
  localparam int MAX_WAIT = RD_WAIT > WR_WAIT ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  sram_state_e            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_W-1:0]      r_addr;
  logic [SRAM_BE_W-1:0]   r_be_n;
  logic [SRAM_DATA_W-1:0] r_wdata;
  logic [SRAM_DATA_W-1:0] r_rdata;
  logic                   r_drive;
  logic                   r_ack;
  logic                   r_ce_n;
  logic                   r_oe_n;
  logic                   r_we_n;
  logic [SRAM_DATA_W-1:0] w_pin_wdata;
  logic [SRAM_DATA_W-1:0] w_rdata;
  logic [SRAM_BE_W-1:0]   w_pin_be;

`ifdef SRAM_CTRL_REVERSE_ENDIAN_EN
  assign w_pin_wdata = reverse_bytes(bus.wdata_i);
  assign w_pin_be    = reverse_be(bus.be_i);
  assign w_rdata     = reverse_bytes(ram_data_io);
`else
  assign w_pin_wdata = bus.wdata_i;
  assign w_pin_be    = bus.be_i;
  assign w_rdata     = ram_data_io;
`endif

  // Pin values are set on the transition into each state, so every pin is a flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_be_n  <= '1;
      r_wdata <= '0;
      r_rdata <= '0;
      r_drive <= 1'b0;
      r_ack   <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.req_i) begin
          r_addr  <= bus.addr_i;
          r_be_n  <= ~w_pin_be;
          r_wdata <= w_pin_wdata;
          r_ce_n  <= 1'b0;
          r_oe_n  <= bus.we_i;
          r_drive <= bus.we_i;
          r_cnt   <= bus.we_i ? '0 : RD_LOAD;
          r_state <= bus.we_i ? ST_WR_SETUP : ST_RD;
        end
        ST_RD: if (r_cnt == '0) begin
          r_rdata <= w_rdata;
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_be_n  <= '1;
          r_ack   <= 1'b1;
          r_state <= ST_RD_DONE;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        ST_RD_DONE: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_cnt   <= WR_LOAD;
          r_state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: if (r_cnt == '0) begin
          r_we_n  <= 1'b1;
          r_ack   <= 1'b1;
          r_state <= ST_WR_HOLD;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        ST_WR_HOLD: begin
          r_ce_n  <= 1'b1;
          r_be_n  <= '1;
          r_drive <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ram_data_io = r_drive ? r_wdata : 'z;
  assign ram_addr_o  = r_addr;
  assign ram_be_n_o  = r_be_n;
  assign ram_ce_n_o  = r_ce_n;
  assign ram_oe_n_o  = r_oe_n;
  assign ram_we_n_o  = r_we_n;
  assign bus.rdata_o = r_rdata;
  assign bus.ack_o   = r_ack;
endmodule
